// File: rtl/codec_cmd_scheduler_pkg.sv
// Shared types and WM8731 register helpers for the codec command scheduler.
// Optional build macro: CODEC_VOL_RAMP_EN (stepwise headphone volume ramp).
package codec_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   typedef enum logic [1:0] {
      C_BOOT,
      C_MUTE,
      C_VOL
   } cmd_t;

   localparam logic [6:0] R2 = 7'h02;
   localparam logic [6:0] R3 = 7'h03;
   localparam logic [6:0] R4 = 7'h04;
   localparam logic [6:0] R5 = 7'h05;
   localparam logic [6:0] R6 = 7'h06;
   localparam logic [6:0] R7 = 7'h07;
   localparam logic [6:0] R8 = 7'h08;
   localparam logic [6:0] R9 = 7'h09;

   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } boot_entry_t;

   // DACMU sits at bit 3; ADC high-pass disable (bit 0) is kept set
   function automatic logic [8:0] mute_data(input logic on);
      return {5'b0, on, 3'b001};
   endfunction

   // both channels, zero-cross enabled
   function automatic logic [8:0] vol_data(input logic [6:0] code);
      return {2'b11, code};
   endfunction

endpackage

// File: rtl/codec_cmd_scheduler_if.sv
// Register-write handshake between the scheduler and the WM8731 I2C master.
// Completion of a write is signalled by busy falling.
interface codec_cmd_scheduler_if;
   logic       action;
   logic [6:0] reg_addr;
   logic [8:0] reg_data;
   logic       busy;

   modport master (
      output action,
      output reg_addr,
      output reg_data,
      input  busy
   );

   modport slave (
      input  action,
      input  reg_addr,
      input  reg_data,
      output busy
   );
endinterface

// File: rtl/codec_cmd_scheduler_init_rom.sv
// WM8731 boot-configuration table, one register write per index.
// The final entry sets the headphone volume to VOL_DEFAULT.
module codec_init_rom
#(
   parameter logic [6:0] VOL_DEFAULT = 7'h79
)
(
   input  logic [2:0]            idx,
   output codec_pkg::boot_entry_t entry
);
   import codec_pkg::*;

   always_comb begin
      entry = '0;
      unique case (idx)
         3'd0: entry = '{addr: R6, data: 9'h0FF};
         3'd1: entry = '{addr: R6, data: 9'h007};
         3'd2: entry = '{addr: R8, data: 9'h002};
         3'd3: entry = '{addr: R7, data: 9'h001};
         3'd4: entry = '{addr: R4, data: 9'h010};
         3'd5: entry = '{addr: R5, data: 9'h001};
         3'd6: entry = '{addr: R9, data: 9'h001};
         default: entry = '{addr: R2, data: vol_data(VOL_DEFAULT)};
      endcase
   end

endmodule

// File: rtl/codec_cmd_scheduler.sv
// Boots the WM8731, then arbitrates mute/volume writes onto the I2C engine.
// Build macro CODEC_VOL_RAMP_EN: volume moves one code per write toward target.
module codec_cmd_scheduler
#(
   parameter int         INIT_LEN    = 8,
   parameter logic [6:0] VOL_DEFAULT = 7'h79,
   parameter int         TIMEOUT_CYC = 262144
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       mute_req,
   input  logic       mute_on,
   output logic       mute_ack,
   input  logic       vol_req,
   input  logic [6:0] vol_level,
   output logic       vol_ack,
   output logic       init_done,
   output logic       err,
   codec_cmd_scheduler_if.master i2c
);
   import codec_pkg::*;

   localparam int CNT_W = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0] IDX_LAST = 3'(INIT_LEN - 1);

   state_t            state_q, state_d;
   cmd_t              cmd_q, cmd_d;
   logic [2:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q;
   logic              action_q, action_d;
   logic [6:0]        addr_q, addr_d;
   logic [8:0]        data_q, data_d;
   logic              mute_ack_q, mute_ack_d;
   logic              vol_ack_q, vol_ack_d;
   logic              init_q, init_d;
   logic              err_q, err_d;
   logic [6:0]        vol_cur_q, vol_cur_d;
   logic [6:0]        step_code;
   logic              done;
   logic              tmo;
   boot_entry_t       rom;

   codec_init_rom #(.VOL_DEFAULT(VOL_DEFAULT)) u_rom (
      .idx   (idx_q),
      .entry (rom)
   );

`ifdef CODEC_VOL_RAMP_EN
   assign step_code = (vol_level > vol_cur_q) ? vol_cur_q + 7'd1 :
                      (vol_level < vol_cur_q) ? vol_cur_q - 7'd1 :
                      vol_cur_q;
`else
   assign step_code = vol_level;
`endif

   assign done = busy_q && !i2c.busy;
   assign tmo  = (cnt_q == TMO_LAST);

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      action_d   = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      mute_ack_d = 1'b0;
      vol_ack_d  = 1'b0;
      init_d     = init_q;
      err_d      = err_q;
      vol_cur_d  = vol_cur_q;
      unique case (state_q)
         S_BOOT: begin
            cmd_d   = C_BOOT;
            state_d = S_ISSUE;
         end
         S_IDLE: begin
            // the ack cycle masks its own still-high request
            if (mute_req && !mute_ack_q) begin
               cmd_d   = C_MUTE;
               state_d = S_ISSUE;
            end else if (vol_req && !vol_ack_q) begin
`ifdef CODEC_VOL_RAMP_EN
               if (vol_level == vol_cur_q) begin
                  vol_ack_d = 1'b1;
               end else begin
                  cmd_d   = C_VOL;
                  state_d = S_ISSUE;
               end
`else
               cmd_d   = C_VOL;
               state_d = S_ISSUE;
`endif
            end
         end
         S_ISSUE: begin
            if (!i2c.busy) begin
               action_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_WAIT;
               unique case (cmd_q)
                  C_MUTE: begin
                     addr_d = R5;
                     data_d = mute_data(mute_on);
                  end
                  C_VOL: begin
                     addr_d = R2;
                     data_d = vol_data(step_code);
                  end
                  default: begin
                     addr_d = rom.addr;
                     data_d = rom.data;
                  end
               endcase
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // an aborted write is still treated as finished
            if (done || tmo) begin
               if (!done) err_d = 1'b1;
               unique case (cmd_q)
                  C_MUTE: begin
                     mute_ack_d = mute_req;
                     state_d    = S_IDLE;
                  end
                  C_VOL: begin
                     vol_cur_d = data_q[6:0];
`ifdef CODEC_VOL_RAMP_EN
                     vol_ack_d = vol_req && (data_q[6:0] == vol_level);
`else
                     vol_ack_d = vol_req;
`endif
                     state_d   = S_IDLE;
                  end
                  default: begin
                     if (idx_q == IDX_LAST) begin
                        init_d  = 1'b1;
                        state_d = S_IDLE;
                     end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_ISSUE;
                     end
                  end
               endcase
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_BOOT;
         cmd_q      <= C_BOOT;
         idx_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         action_q   <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         mute_ack_q <= 1'b0;
         vol_ack_q  <= 1'b0;
         init_q     <= 1'b0;
         err_q      <= 1'b0;
         vol_cur_q  <= VOL_DEFAULT;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         busy_q     <= i2c.busy;
         action_q   <= action_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         mute_ack_q <= mute_ack_d;
         vol_ack_q  <= vol_ack_d;
         init_q     <= init_d;
         err_q      <= err_d;
         vol_cur_q  <= vol_cur_d;
      end
   end

   assign i2c.action   = action_q;
   assign i2c.reg_addr = addr_q;
   assign i2c.reg_data = data_q;
   assign mute_ack     = mute_ack_q;
   assign vol_ack      = vol_ack_q;
   assign init_done    = init_q;
   assign err          = err_q;

endmodule

// File: tb/tb_codec_cmd_scheduler.sv
// Randomized bench for codec_cmd_scheduler against a write-list/ack-order model.
// Follows CODEC_VOL_RAMP_EN when defined for the build.
module tb_codec_cmd_scheduler;

   localparam int  TMO = 2048;
   localparam byte AM  = 8'h4D;
   localparam byte AV  = 8'h56;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       mute_req = 1'b0;
   logic       mute_on = 1'b0;
   logic       vol_req = 1'b0;
   logic [6:0] vol_level = 7'h00;
   logic       mute_ack, vol_ack, init_done, err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_act = 0;
   int blen = 500;
   bit hang = 1'b0;
   logic [6:0] mvol = 7'h79;

   logic [15:0] wq[$];
   logic [15:0] eq[$];
   byte         aq[$];
   byte         ea[$];
   logic [15:0] boot_tbl[8];

   codec_cmd_scheduler_if i2c();

   codec_cmd_scheduler #(
      .INIT_LEN    (8),
      .VOL_DEFAULT (7'h79),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .mute_req  (mute_req),
      .mute_on   (mute_on),
      .mute_ack  (mute_ack),
      .vol_req   (vol_req),
      .vol_level (vol_level),
      .vol_ack   (vol_ack),
      .init_done (init_done),
      .err       (err),
      .i2c       (i2c)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // WM8731 stand-in: logs each write, holds busy for blen cycles
   initial begin
      logic [15:0] w;
      int n;
      i2c.busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            i2c.busy = 1'b0;
         end else if (i2c.action) begin
            w = {i2c.reg_addr, i2c.reg_data};
            wq.push_back(w);
            last_act = cyc;
            if (!hang) begin
               i2c.busy = 1'b1;
               n = 0;
               while (n < blen && reset) begin
                  @(negedge clk);
                  n++;
               end
               if (reset) chk("hold", {i2c.reg_addr, i2c.reg_data}, w);
               i2c.busy = 1'b0;
            end
         end
      end
   end

   task automatic model_vol(input logic [6:0] lvl);
`ifdef CODEC_VOL_RAMP_EN
      while (mvol != lvl) begin
         mvol = (lvl > mvol) ? mvol + 7'd1 : mvol - 7'd1;
         eq.push_back({7'h02, 2'b11, mvol});
      end
`else
      eq.push_back({7'h02, 2'b11, lvl});
      mvol = lvl;
`endif
   endtask

   task automatic compare(input string tag);
      chk({tag, "_nwr"}, wq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++)
         if (i < wq.size()) chk({tag, "_wr"}, wq[i], eq[i]);
      chk({tag, "_nack"}, aq.size(), ea.size());
      for (int i = 0; i < ea.size(); i++)
         if (i < aq.size()) chk({tag, "_ack"}, aq[i], ea[i]);
      wq.delete();
      eq.delete();
      aq.delete();
      ea.delete();
   endtask

   task automatic serve(input string tag, input int budget);
      int n = 0;
      while ((mute_req || vol_req) && n < budget) begin
         @(negedge clk);
         n++;
         if (mute_ack) begin
            aq.push_back(AM);
            mute_req = 1'b0;
         end
         if (vol_ack) begin
            aq.push_back(AV);
            vol_req = 1'b0;
         end
      end
      if (mute_req || vol_req) begin
         chk({tag, "_budget"}, 0, 1);
         mute_req = 1'b0;
         vol_req  = 1'b0;
      end
      repeat (20) begin
         @(negedge clk);
         if (mute_ack) aq.push_back(AM);
         if (vol_ack) aq.push_back(AV);
      end
      compare(tag);
   endtask

   task automatic run_txn(input string tag, input bit m, input bit mon,
                          input bit v, input logic [6:0] lvl);
      @(negedge clk);
      mute_on   = mon;
      vol_level = lvl;
      if (m) begin
         mute_req = 1'b1;
         eq.push_back({7'h05, 5'b0, mon, 3'b001});
         ea.push_back(AM);
      end
      if (v) begin
         vol_req = 1'b1;
         model_vol(lvl);
         ea.push_back(AV);
      end
      serve(tag, 6000);
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      int early = 0;
      while (!init_done && n < 6000) begin
         @(negedge clk);
         n++;
         if (mute_ack || vol_ack) early++;
      end
      chk({tag, "_done"}, init_done, 1);
      chk({tag, "_early"}, early, 0);
      for (int i = 0; i < 8; i++) eq.push_back(boot_tbl[i]);
      compare(tag);
   endtask

   initial begin
      int n, err_cyc, t;
      bit m, v, mon;
      logic [6:0] lvl;
      boot_tbl = '{16'h0CFF, 16'h0C07, 16'h1002, 16'h0E01,
                   16'h0810, 16'h0A01, 16'h1201, 16'h05F9};

      repeat (3) @(negedge clk);
      chk("rst_action", i2c.action, 0);
      chk("rst_addr", i2c.reg_addr, 0);
      chk("rst_data", i2c.reg_data, 0);
      chk("rst_init", init_done, 0);
      chk("rst_err", err, 0);
      chk("rst_acks", {mute_ack, vol_ack}, 0);

      // volume request held through boot
      vol_req   = 1'b1;
      vol_level = 7'h60;
      blen      = 500;
      reset     = 1'b1;
      wait_init("boot");
      blen = 4;
      model_vol(7'h60);
      ea.push_back(AV);
      serve("boot_vol", 6000);

      run_txn("both", 1'b1, 1'b1, 1'b1, 7'h50);
      run_txn("equal", 1'b0, 1'b0, 1'b1, mvol);
      run_txn("to79", 1'b0, 1'b0, 1'b1, 7'h79);
      run_txn("to76", 1'b0, 1'b0, 1'b1, 7'h76);
      run_txn("unmute", 1'b1, 1'b0, 1'b0, 7'h00);

      for (int it = 0; it < 20; it++) begin
         blen = $urandom_range(1, 12);
         t    = $urandom_range(0, 2);
         m    = (t != 1);
         v    = (t != 0);
         mon  = 1'($urandom_range(0, 1));
`ifdef CODEC_VOL_RAMP_EN
         t = int'(mvol) + $urandom_range(0, 12) - 6;
         if (t < 0) t = 0;
         if (t > 127) t = 127;
         lvl = 7'(t);
`else
         lvl = 7'($urandom_range(0, 127));
`endif
         run_txn("rand", m, mon, v, lvl);
      end

      // write that never sees busy: abort, err, ack still given
      hang = 1'b1;
      @(negedge clk);
      mute_on  = 1'b0;
      mute_req = 1'b1;
      eq.push_back({7'h05, 9'h001});
      ea.push_back(AM);
      n = 0;
      err_cyc = -1;
      while (mute_req && n < TMO + 200) begin
         @(negedge clk);
         n++;
         if (err && err_cyc < 0) err_cyc = cyc;
         if (mute_ack) begin
            aq.push_back(AM);
            mute_req = 1'b0;
         end
      end
      if (mute_req) begin
         chk("tmo_budget", 0, 1);
         mute_req = 1'b0;
      end
      chk("tmo_err", err, 1);
      chk("tmo_lat", err_cyc - last_act, TMO);
      compare("tmo");
      hang = 1'b0;
      run_txn("post_tmo", 1'b0, 1'b0, 1'b1, 7'h40);
      chk("err_sticky", err, 1);

      // reset in the middle of boot, at the fifth table entry
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      wq.delete();
      blen  = 500;
      reset = 1'b1;
      n = 0;
      while (wq.size() < 5 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_wr4", wq.size(), 5);
      reset = 1'b0;
      @(negedge clk);
      chk("mid_action", i2c.action, 0);
      chk("mid_addr", i2c.reg_addr, 0);
      chk("mid_data", i2c.reg_data, 0);
      chk("mid_init", init_done, 0);
      chk("mid_err", err, 0);
      chk("mid_busy", i2c.busy, 0);
      wq.delete();
      mvol  = 7'h79;
      reset = 1'b1;
      wait_init("reboot");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
